// File: rtl/gray_server_pkg.sv
// gray_server_pkg: frame geometry defaults and server state encoding
package gray_server_pkg;
  localparam int N_PIX = 16384;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, LOAD, SERVE, DONE} state_t;
endpackage

// File: rtl/gray_frame_ram.sv
// gray_frame_ram: N_PIX x DATA_W frame store, sync write, async read
module gray_frame_ram
  import gray_server_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [N_PIX];
  // write port; contents survive reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/gray_mem_server.sv
// gray_mem_server: loads one frame from a host stream, then serves gray_* reads until finish (GRAY_SERVER_STATS_EN adds req_count)
module gray_mem_server
  import gray_server_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              finish,
  output logic              frame_done
`ifdef GRAY_SERVER_STATS_EN
  ,
  output logic [ADDR_W:0]   req_count
`endif
);
  state_t state, state_n;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] rdata;
  logic beat, last, in_range;
  assign beat = state == LOAD && load_valid;
  assign last = wr_ptr == ADDR_W'(N_PIX - 1);
  assign in_range = {1'b0, gray_addr} < (ADDR_W + 1)'(N_PIX);
  assign load_ready = state == LOAD;
  assign gray_ready = state == SERVE;
  assign frame_done = state == DONE;
  assign gray_data = (gray_ready && gray_req && in_range) ? rdata : '0;
  gray_frame_ram u_ram (
    .clk  (clk),
    .we   (beat),
    .waddr(wr_ptr),
    .wdata(load_data),
    .raddr(gray_addr),
    .rdata(rdata)
  );
  // state register and write pointer; pointer rests at 0 outside LOAD
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
    end else begin
      state <= state_n;
      wr_ptr <= beat ? wr_ptr + 1'b1 : (state == LOAD ? wr_ptr : '0);
    end
  // next-state: the restart beat in DONE only triggers LOAD, it is not stored
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = LOAD;
      LOAD:    state_n = (beat && last) ? SERVE : LOAD;
      SERVE:   state_n = finish ? DONE : SERVE;
      default: state_n = load_valid ? LOAD : DONE;
    endcase
  end
`ifdef GRAY_SERVER_STATS_EN
  // saturating count of request cycles served; cleared on every entry to LOAD
  always_ff @(posedge clk)
    if (reset || (state_n == LOAD && state != LOAD)) req_count <= '0;
    else if (state == SERVE && gray_req && !(&req_count)) req_count <= req_count + 1'b1;
`endif
endmodule
